alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one combinational 8-bit ALU between NUM_REQ requesters.
- Each request carries A, B and an enum_pkg::Opcode. The block accepts one request, drives the ALU from registered operands, and captures the 8-bit result. It then returns the result with the requester ID over a valid/ready response channel.
- Sits between requester agents and the ALU instance; the ALU itself is external.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..16.
- ID_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), width of the requester ID; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ x 8  operand A per requester, unpacked array.
- req_b  input  NUM_REQ x 8  operand B per requester, unpacked array.
- req_op  input  NUM_REQ x Opcode  operation per requester, unpacked array of enum_pkg::Opcode.
- alu_a  output  8  registered operand A to ALU.
- alu_b  output  8  registered operand B to ALU.
- alu_op  output  Opcode  registered opcode to ALU.
- alu_out  input  8  ALU combinational result.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- rsp_data  output  8  captured ALU result.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=8'h00, alu_a=8'h00, alu_b=8'h00, alu_op=Add. Any in-flight op is discarded; no response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE, no req_valid bits set: stay in IDLE; req_ready=0.
- IDLE, any req_valid set:
  - Winner is the first set bit searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the clock edge, latch req_a/req_b/req_op[winner] into alu_a/alu_b/alu_op and the winner index into rsp_id; go to EXEC.
- EXEC: the ALU settles on the registered inputs. At the edge, rsp_data<=alu_out, rsp_valid<=1; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, rr_ptr<=(rsp_id==NUM_REQ-1)?0:rsp_id+1, go to IDLE.
  - Backpressure (rsp_ready=0) holds RESP indefinitely. req_ready stays 0 in EXEC and RESP.
- Latency: accept edge at cycle T -> rsp_valid high from T+2. Minimum issue spacing is 3 cycles (accept, exec, resp-handshake).
- Request handshake: a requester must hold valid and payload stable until it sees req_ready. req_ready is never asserted without the matching req_valid. req_valid dropping before grant is legal; that requester is simply not chosen.
- alu_a/alu_b/alu_op change only on the accept edge; they hold between ops.
- Results are passed through unmodified. Equal yields 8'h01 or 8'h00. Opcodes outside the enum produce whatever the ALU returns (8'h00 by ALU default).
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.
- NUM_REQ=1: rr_ptr stays 0; rsp_id is always 0.

Optional Feature:
- Macro: ALU_ARB_OPCOUNT_EN.
- Defined: adds output op_count [15:0]. Reset value 0. It increments on every accept edge and saturates at 16'hFFFF (no wrap). Reset mid-operation clears it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single op: req_valid=4'b0001, A=8'h0F, B=8'h01, op=Add -> req_ready[0] in cycle T, rsp_valid at T+2 with rsp_data=8'h10 and rsp_id=0.
- Round-robin: all four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0; each response carries the matching ID and result.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id stable, req_ready=0 throughout. Release gives one handshake, then IDLE.
- Wrap and skip: rr_ptr=3 after granting requester 2, req_valid=4'b0101 -> requester 0 is granted (wraps past 3), then requester 2.
- Ops: A=8'h80, B=8'h80, Equal -> 8'h01. A=8'hF0, B=8'h0F, Xor -> 8'hFF. A=8'h05, B=8'h07, Sub -> 8'hFE.
- Reset in EXEC: rst pulsed one cycle while in EXEC -> rsp_valid stays 0 and the next grant starts from requester 0. With ALU_ARB_OPCOUNT_EN defined, op_count reads 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: opcode package plus the requester/ALU/response bundle of the arbiter
package enum_pkg;
  typedef enum logic [2:0] {
    Add   = 3'd0,
    Sub   = 3'd1,
    And   = 3'd2,
    Or    = 3'd3,
    Xor   = 3'd4,
    Equal = 3'd5
  } Opcode;
endpackage

interface alu_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [7:0]         req_a [NUM_REQ];
  logic [7:0]         req_b [NUM_REQ];
  enum_pkg::Opcode    req_op [NUM_REQ];
  logic [7:0]         alu_a;
  logic [7:0]         alu_b;
  enum_pkg::Opcode    alu_op;
  logic [7:0]         alu_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [7:0]         rsp_data;
  // environment side: requesters, external ALU and response consumer
  modport master (
    output req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
  );
  // arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external 8-bit ALU; ALU_ARB_OPCOUNT_EN adds op_count
module alu_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic         clk,
  input  logic         rst,
`ifdef ALU_ARB_OPCOUNT_EN
  output logic [15:0]  op_count,
`endif
  alu_arbiter_if.slave bus
);
  import enum_pkg::*;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         alu_a_q, alu_a_d;
  logic [7:0]         alu_b_q, alu_b_d;
  Opcode              alu_op_q, alu_op_d;
  logic [ID_W-1:0]    win;
  logic [ID_W:0]      idx;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  assign accept        = (state_q == IDLE) && (|bus.req_valid) && !rst;
  assign bus.req_ready = grant;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  // scan downward so the last hit is the first valid requester at or after rr_ptr
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (bus.req_valid[idx[ID_W-1:0]]) win = idx[ID_W-1:0];
    end
  end
  // sequencer: accept -> execute -> hold response until consumed
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    grant       = '0;
    case (state_q)
      IDLE: if (accept) begin
        grant[win] = 1'b1;
        alu_a_d    = bus.req_a[win];
        alu_b_d    = bus.req_b[win];
        alu_op_d   = bus.req_op[win];
        rsp_id_d   = win;
        state_d    = EXEC;
      end
      EXEC: begin
        rsp_data_d  = bus.alu_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_op_q    <= Add;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
    end
  end
`ifdef ALU_ARB_OPCOUNT_EN
  logic [15:0] op_count_q, op_count_d;
  assign op_count = op_count_q;
  // saturating count of accepted requests
  always_comb op_count_d = (accept && !(&op_count_q)) ? op_count_q + 16'd1 : op_count_q;
  // accept counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= 16'h0000;
    else op_count_q <= op_count_d;
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import enum_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total = 0;
  always #5 clk = ~clk;
  alu_arbiter_if #(.NUM_REQ(4)) bus();
`ifdef ALU_ARB_OPCOUNT_EN
  logic [15:0] op_count;
`endif
  alu_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef ALU_ARB_OPCOUNT_EN
    .op_count(op_count),
`endif
    .bus(bus)
  );
  always_comb begin
    case (bus.alu_op)
      Add:     bus.alu_out = bus.alu_a + bus.alu_b;
      Sub:     bus.alu_out = bus.alu_a - bus.alu_b;
      And:     bus.alu_out = bus.alu_a & bus.alu_b;
      Or:      bus.alu_out = bus.alu_a | bus.alu_b;
      Xor:     bus.alu_out = bus.alu_a ^ bus.alu_b;
      Equal:   bus.alu_out = (bus.alu_a == bus.alu_b) ? 8'h01 : 8'h00;
      default: bus.alu_out = 8'h00;
    endcase
  end
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input Opcode op);
    bus.req_a[i]  = a;
    bus.req_b[i]  = b;
    bus.req_op[i] = op;
  endtask
  task automatic test_reset();
    bus.req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); else pass_cnt++;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); else pass_cnt++;
    total++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); else pass_cnt++;
    total++; if (bus.rsp_data !== 8'h00) $display("FAIL reset_rsp_data got=%h exp=00", bus.rsp_data); else pass_cnt++;
    total++; if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00) $display("FAIL reset_alu_ab got=%h/%h exp=00/00", bus.alu_a, bus.alu_b); else pass_cnt++;
    total++; if (bus.alu_op !== Add) $display("FAIL reset_alu_op got=%0d exp=%0d", bus.alu_op, Add); else pass_cnt++;
`ifdef ALU_ARB_OPCOUNT_EN
    total++; if (op_count !== 16'd0) $display("FAIL reset_op_count got=%0d exp=0", op_count); else pass_cnt++;
`endif
    bus.req_valid = 4'b0000;
    rst = 1'b0;
  endtask
  task automatic test_single();
    @(negedge clk);
    set_req(0, 8'h0F, 8'h01, Add);
    bus.req_valid = 4'b0001;
    #1;
    total++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    total++; if (bus.alu_a !== 8'h0F || bus.alu_b !== 8'h01 || bus.alu_op !== Add) $display("FAIL single_alu_in got=%h/%h/%0d exp=0f/01/0", bus.alu_a, bus.alu_b, bus.alu_op); else pass_cnt++;
    total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) $display("FAIL single_exec got_valid=%b got_ready=%b exp=0/0000", bus.rsp_valid, bus.req_ready); else pass_cnt++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h10 || bus.rsp_id !== 2'd0) $display("FAIL single_rsp got=%b/%h/%0d exp=1/10/0", bus.rsp_valid, bus.rsp_data, bus.rsp_id); else pass_cnt++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_done got=%b exp=0", bus.rsp_valid); else pass_cnt++;
  endtask
  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    int exp_id [5];
    exp_data = '{8'h03, 8'h0F, 8'hFF, 8'h01};
    exp_id = '{0, 1, 2, 3, 0};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 8'h01, 8'h02, Add);
    set_req(1, 8'h10, 8'h01, Sub);
    set_req(2, 8'hF0, 8'h0F, Xor);
    set_req(3, 8'h80, 8'h80, Equal);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (bus.req_ready !== (4'b0001 << exp_id[k])) $display("FAIL rr_grant%0d got=%b exp_id=%0d", k, bus.req_ready, exp_id[k]); else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(exp_id[k]) || bus.rsp_data !== exp_data[exp_id[k]]) $display("FAIL rr_rsp%0d got=%b/%0d/%h exp=1/%0d/%h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_id[k], exp_data[exp_id[k]]); else pass_cnt++;
      @(negedge clk);
    end
    bus.req_valid = 4'b0000;
  endtask
  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    set_req(1, 8'h05, 8'h07, Sub);
    bus.req_valid = 4'b0010;
    #1;
    total++; if (bus.req_ready !== 4'b0010) $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    total++; if (bus.req_ready !== 4'b0000) $display("FAIL bp_exec_ready got=%b exp=0000", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hFE || bus.rsp_id !== 2'd1) $display("FAIL bp_rsp got=%b/%h/%0d exp=1/fe/1", bus.rsp_valid, bus.rsp_data, bus.rsp_id); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hFE || bus.rsp_id !== 2'd1 || bus.req_ready !== 4'b0000) $display("FAIL bp_hold%0d got=%b/%h/%0d/%b exp=1/fe/1/0000", k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready); else pass_cnt++;
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_release got=%b exp=0", bus.rsp_valid); else pass_cnt++;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) $display("FAIL bp_idle got=%b/%b exp=0/0000", bus.rsp_valid, bus.req_ready); else pass_cnt++;
  endtask
  task automatic test_wrap_skip();
    set_req(2, 8'hF0, 8'h0F, Xor);
    bus.req_valid = 4'b0100;
    #1;
    total++; if (bus.req_ready !== 4'b0100) $display("FAIL wrap_grant2 got=%b exp=0100", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total++; if (bus.rsp_id !== 2'd2 || bus.rsp_data !== 8'hFF) $display("FAIL wrap_xor got=%0d/%h exp=2/ff", bus.rsp_id, bus.rsp_data); else pass_cnt++;
    @(negedge clk);
    set_req(0, 8'h80, 8'h80, Equal);
    set_req(2, 8'h22, 8'h11, Add);
    bus.req_valid = 4'b0101;
    #1;
    total++; if (bus.req_ready !== 4'b0001) $display("FAIL wrap_grant0 got=%b exp=0001", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    total++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h01) $display("FAIL wrap_equal got=%0d/%h exp=0/01", bus.rsp_id, bus.rsp_data); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (bus.req_ready !== 4'b0100) $display("FAIL skip_grant2 got=%b exp=0100", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total++; if (bus.rsp_id !== 2'd2 || bus.rsp_data !== 8'h33) $display("FAIL skip_add got=%0d/%h exp=2/33", bus.rsp_id, bus.rsp_data); else pass_cnt++;
    @(negedge clk);
    total++; if (bus.alu_a !== 8'h22 || bus.alu_b !== 8'h11) $display("FAIL alu_hold got=%h/%h exp=22/11", bus.alu_a, bus.alu_b); else pass_cnt++;
  endtask
  task automatic test_reset_exec();
    set_req(3, 8'hAA, 8'h55, Or);
    bus.req_valid = 4'b1000;
    #1;
    total++; if (bus.req_ready !== 4'b1000) $display("FAIL rx_grant3 got=%b exp=1000", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    total++; if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 8'h00 || bus.alu_op !== Add) $display("FAIL rx_async got=%b/%h/%0d exp=0/00/0", bus.rsp_valid, bus.alu_a, bus.alu_op); else pass_cnt++;
`ifdef ALU_ARB_OPCOUNT_EN
    total++; if (op_count !== 16'd0) $display("FAIL rx_op_count got=%0d exp=0", op_count); else pass_cnt++;
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rx_no_rsp got=%b exp=0", bus.rsp_valid); else pass_cnt++;
    bus.req_valid = 4'b1111;
    #1;
    total++; if (bus.req_ready !== 4'b0001) $display("FAIL rx_restart got=%b exp=0001", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
`ifdef ALU_ARB_OPCOUNT_EN
    total++; if (op_count !== 16'd1) $display("FAIL rx_op_count_inc got=%0d exp=1", op_count); else pass_cnt++;
`endif
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h01) $display("FAIL rx_rsp got=%b/%0d/%h exp=1/0/01", bus.rsp_valid, bus.rsp_id, bus.rsp_data); else pass_cnt++;
    @(negedge clk);
  endtask
  initial begin
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 8'h00, 8'h00, Add);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_exec();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end
endmodule
